// File: rtl/tdm_demux.sv
// TDM receive de-interleaver: locks to frame_sync, routes samples to channel registers.
// Optional DEMUX_FRAME_BUF_EN: shadow-buffer each frame and publish all channels at once.
module tdm_demux #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      frame_sync,
  output logic [CHANNELS*WIDTH-1:0] ch_data,
  output logic [CHANNELS-1:0]       ch_valid,
  output logic                      frame_done,
  output logic                      sync_err
);

  localparam int unsigned SW = $clog2(CHANNELS);
  localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

  typedef enum logic {HUNT, RUN} state_t;

  state_t        state;
  logic [SW-1:0] slot;

  logic          accept_c;
  logic          realign_c;
  logic          last_c;
  logic [SW-1:0] wslot_c;

  // A sync always forces slot 0; unsynced samples only count once locked.
  always_comb begin
    accept_c  = din_valid && (frame_sync || state == RUN);
    realign_c = accept_c && frame_sync && state == RUN && slot != '0;
    last_c    = accept_c && !frame_sync && slot == LAST;
    wslot_c   = frame_sync ? '0 : slot;
  end

  // Lock state, slot counter and frame status strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= last_c;
      sync_err   <= realign_c;
      if (accept_c) begin
        state <= RUN;
        slot  <= last_c ? '0 : wslot_c + SW'(1);
      end
    end
  end

`ifdef DEMUX_FRAME_BUF_EN
  logic [WIDTH-1:0] shadow [CHANNELS-1];

  // Slots before the last collect in shadow; the last slot publishes the whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_data  <= '0;
      ch_valid <= '0;
      for (int unsigned k = 0; k < CHANNELS - 1; k++) shadow[k] <= '0;
    end else begin
      ch_valid <= last_c ? '1 : '0;
      for (int unsigned k = 0; k < CHANNELS - 1; k++) begin
        if (accept_c && !last_c && wslot_c == SW'(k)) shadow[k] <= din;
        if (last_c) ch_data[k*WIDTH +: WIDTH] <= shadow[k];
      end
      if (last_c) ch_data[(CHANNELS-1)*WIDTH +: WIDTH] <= din;
    end
  end
`else
  // Per-slot update: each accepted sample lands directly in its channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_data  <= '0;
      ch_valid <= '0;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        ch_valid[k] <= accept_c && wslot_c == SW'(k);
        if (accept_c && wslot_c == SW'(k)) ch_data[k*WIDTH +: WIDTH] <= din;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux (WIDTH=8, CHANNELS=4); honours DEMUX_FRAME_BUF_EN.
module tb_tdm_demux;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 4;
`ifdef DEMUX_FRAME_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    din = '0;
  logic            din_valid = 1'b0;
  logic            frame_sync = 1'b0;
  logic [CH*W-1:0] ch_data;
  logic [CH-1:0]   ch_valid;
  logic            frame_done;
  logic            sync_err;

  tdm_demux #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .ch_data(ch_data), .ch_valid(ch_valid), .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH*W-1:0] data;
    logic [CH-1:0]   valid;
    logic            done;
    logic            err;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nfail = 0;

  // Reference model: lock flag, frame position, visible channels, pending frame.
  bit         locked = 1'b0;
  int         pos = 0;
  logic [7:0] chan [CH];
  logic [7:0] shad [CH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Drive one cycle of inputs and push the output expected one edge later.
  task automatic cyc(input bit r, input bit dv, input bit fs, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    rst = r; din_valid = dv; frame_sync = fs; din = d;
    e.valid = '0; e.done = 1'b0; e.err = 1'b0;
    if (r) begin
      locked = 1'b0; pos = 0;
      for (int k = 0; k < CH; k++) begin chan[k] = '0; shad[k] = '0; end
    end else if (dv && (fs || locked)) begin
      if (fs) begin
        e.err  = locked && pos != 0;
        locked = 1'b1;
        pos    = 0;
      end
      if (BUF) begin
        if (pos == CH - 1) begin
          for (int k = 0; k < CH - 1; k++) chan[k] = shad[k];
          chan[CH-1] = d;
          e.valid = '1;
        end else begin
          shad[pos] = d;
        end
      end else begin
        chan[pos] = d;
        e.valid[pos] = 1'b1;
      end
      e.done = (pos == CH - 1);
      pos = (pos + 1) % CH;
    end
    for (int k = 0; k < CH; k++) e.data[k*W +: W] = chan[k];
    q.push_back(e);
  endtask

  // Monitor: one expectation per cycle, compared just after the capturing edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ch_data",    64'(ch_data),    64'(e.data));
      chk("ch_valid",   64'(ch_valid),   64'(e.valid));
      chk("frame_done", 64'(frame_done), 64'(e.done));
      chk("sync_err",   64'(sync_err),   64'(e.err));
    end
  end

  task automatic frame2();
    cyc(0, 1, 1, 8'hA0);
    cyc(0, 1, 0, 8'hA1);
    cyc(0, 1, 0, 8'hA2);
    cyc(0, 1, 0, 8'hA3);
  endtask

  task automatic realign4();
    cyc(0, 1, 0, 8'hC0);
    cyc(0, 1, 0, 8'hC1);
    cyc(0, 1, 1, 8'hD0);
    cyc(0, 1, 0, 8'hD1);
    cyc(0, 0, 0, 8'h00);
  endtask

  initial begin
    for (int k = 0; k < CH; k++) begin chan[k] = '0; shad[k] = '0; end

    // Reset held while inputs toggle, then unsynced samples are dropped.
    for (int i = 0; i < 6; i++) cyc(1, 1'($urandom), 1'($urandom), 8'($urandom));
    cyc(0, 1, 0, 8'h11);
    cyc(0, 1, 0, 8'h22);
    cyc(0, 0, 0, 8'h00);

    // Lock and one back-to-back frame.
    frame2();
    cyc(0, 0, 0, 8'h00);

    // Gapped frame without sync; a sync without din_valid must be ignored.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 8'(8'hB0 + i));
      cyc(0, 0, 1, 8'h5A);
      cyc(0, 0, 0, 8'h00);
    end

    // Misaligned sync mid-frame.
    realign4();

    // Reset pulse mid-frame, then an unsynced sample is dropped.
    cyc(0, 1, 1, 8'h70);
    cyc(0, 1, 0, 8'h71);
    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'hE0);
    cyc(0, 0, 0, 8'h00);

    // Full frame then realign again (exercises shadow discard when buffered).
    frame2();
    realign4();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 100) == 0, ($urandom % 10) < 7, ($urandom % 10) == 0, 8'($urandom));

    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00);
    @(posedge clk);
    #3;
    chk("queue_drain", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
